// File: rtl/id_ex_stage.sv
`timescale 1ns/1ps
// ID/EX pipeline register: captures decoded operands/control, forwards from EX/MEM and
// MEM/WB, and raises load-use hazards. Define IDEX_PERF_CNT_EN to add the bubble counter.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [RW-1:0] id_rs_addr,
  input  logic [RW-1:0] id_rt_addr,
  input  logic [RW-1:0] id_rd_addr,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [3:0]    id_alu_ctrl,
  input  logic          id_alu_src_imm,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          mem_reg_write,
  input  logic [RW-1:0] mem_rd_addr,
  input  logic [DW-1:0] mem_alu_res,
  input  logic          wb_reg_write,
  input  logic [RW-1:0] wb_rd_addr,
  input  logic [DW-1:0] wb_data,
  output logic          ex_valid,
  output logic [DW-1:0] alu_A,
  output logic [DW-1:0] alu_B,
  output logic [3:0]    alu_ctrl,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_rd_addr,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg,
  output logic          load_use_hazard
`ifdef IDEX_PERF_CNT_EN
  ,output logic [31:0]  bubble_cnt
`endif
);

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rs_addr;
    logic [RW-1:0] rt_addr;
    logic [RW-1:0] rd_addr;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [3:0]    alu_ctrl;
    logic          alu_src_imm;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
  } ex_t;

  ex_t ex_q, ex_d;
  logic [DW-1:0] fwd_rs, fwd_rt;

  function automatic logic [DW-1:0] fwd(input logic [RW-1:0] a, input logic [DW-1:0] stored);
    if (mem_reg_write && mem_rd_addr != '0 && mem_rd_addr == a)     fwd = mem_alu_res;
    else if (wb_reg_write && wb_rd_addr != '0 && wb_rd_addr == a)   fwd = wb_data;
    else                                                           fwd = stored;
  endfunction

  assign fwd_rs = fwd(ex_q.rs_addr, ex_q.rs_data);
  assign fwd_rt = fwd(ex_q.rt_addr, ex_q.rt_data);

  assign load_use_hazard = ex_q.valid & ex_q.mem_read & (ex_q.rd_addr != '0) & in_valid &
                           ((ex_q.rd_addr == id_rs_addr) | (ex_q.rd_addr == id_rt_addr));

  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (stall) begin
      // Refresh held operands so a producer retiring mid-stall is captured.
      ex_d.rs_data = fwd_rs;
      ex_d.rt_data = fwd_rt;
    end else if (load_use_hazard) begin
      ex_d = '0;
    end else begin
      ex_d.valid       = in_valid;
      ex_d.rs_addr     = id_rs_addr;
      ex_d.rt_addr     = id_rt_addr;
      ex_d.rd_addr     = id_rd_addr;
      ex_d.rs_data     = id_rs_data;
      ex_d.rt_data     = id_rt_data;
      ex_d.imm         = id_imm;
      ex_d.alu_ctrl    = id_alu_ctrl;
      ex_d.alu_src_imm = id_alu_src_imm;
      ex_d.reg_write   = in_valid & id_reg_write;
      ex_d.mem_read    = in_valid & id_mem_read;
      ex_d.mem_write   = in_valid & id_mem_write;
      ex_d.mem_to_reg  = in_valid & id_mem_to_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  assign ex_valid      = ex_q.valid;
  assign alu_A         = fwd_rs;
  assign alu_B         = ex_q.alu_src_imm ? ex_q.imm : fwd_rt;
  assign alu_ctrl      = ex_q.alu_ctrl;
  assign ex_store_data = fwd_rt;
  assign ex_rd_addr    = ex_q.rd_addr;
  assign ex_reg_write  = ex_q.valid & ex_q.reg_write;
  assign ex_mem_read   = ex_q.valid & ex_q.mem_read;
  assign ex_mem_write  = ex_q.valid & ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.valid & ex_q.mem_to_reg;

`ifdef IDEX_PERF_CNT_EN
  logic [31:0] bubble_cnt_q;
  always_ff @(posedge clk) begin
    if (rst)                                    bubble_cnt_q <= '0;
    else if (flush | (load_use_hazard & ~stall)) bubble_cnt_q <= bubble_cnt_q + 32'd1;
  end
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage CPU, directly upstream of the ALU.
- Captures decoded operands and control from ID, resolves RAW hazards through EX/MEM and MEM/WB forwarding, and detects load-use hazards.
- Drives ALU inputs A, B and ALU_Ctrl plus the control bits carried to EX/MEM.
- Supports stall (hold), flush (bubble) and self-inserted load-use bubbles.

Parameters:
- DW, 32, datapath width
- RW, 5, register address width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold current contents (downstream busy)
- flush  in  1  replace contents with bubble (branch/jump redirect)
- in_valid  in  1  ID holds a real instruction
- id_rs_addr, id_rt_addr, id_rd_addr  in  RW  source/dest register numbers
- id_rs_data, id_rt_data  in  DW  register-file read data
- id_imm  in  DW  extended immediate
- id_alu_ctrl  in  4  ALU operation code
- id_alu_src_imm  in  1  B = imm when 1, else rt
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  control bits
- mem_reg_write  in  1  EX/MEM writes a register
- mem_rd_addr  in  RW  EX/MEM destination
- mem_alu_res  in  DW  EX/MEM result
- wb_reg_write  in  1  MEM/WB writes a register
- wb_rd_addr  in  RW  MEM/WB destination
- wb_data  in  DW  MEM/WB write-back data
- ex_valid  out  1  EX holds a real instruction
- alu_A, alu_B  out  DW  forwarded ALU operands
- alu_ctrl  out  4  registered ALU code
- ex_store_data  out  DW  forwarded rt for stores
- ex_rd_addr  out  RW  registered destination
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  registered control, gated by ex_valid
- load_use_hazard  out  1  combinational; ID must hold when 1

Behaviour:
- Update priority each edge: rst > flush > stall > load_use_hazard > normal load.
- Reset: all registers zero. ex_valid=0, alu_ctrl=0, every control bit 0, addresses 0, data 0. alu_A/alu_B/ex_store_data read 0 in the cycle after reset unless forwarding applies.
- Flush: loads a bubble (valid=0, controls=0, addresses=0, data=0) even if stall=1.
- Stall, no flush: addresses, control and imm hold. Stored rs/rt data is rewritten with its forwarded value each stalled cycle, so a producer that retires during the stall is not lost.
- load_use_hazard = ex_valid & ex_mem_read & ex_rd_addr!=0 & in_valid & (ex_rd_addr==id_rs_addr | ex_rd_addr==id_rt_addr). When it is 1 and there is no stall or flush, the block loads a bubble. Upstream holds ID; the instruction reloads next cycle with a single bubble.
- Normal: all fields load from ID. ex_valid=in_valid. If in_valid=0, control bits load 0.
- Forwarding (combinational on registered rs/rt): MEM match (mem_reg_write, mem_rd_addr!=0, equal) uses mem_alu_res. Otherwise a WB match uses wb_data. Otherwise stored data. MEM beats WB when both match. Register 0 is never forwarded.
- alu_A = fwd_rs. alu_B = id_alu_src_imm_q ? imm_q : fwd_rt. ex_store_data = fwd_rt always.
- Latency: 1 cycle ID→EX. No combinational path from id_* to alu_* except through load_use_hazard.

Optional Feature:
- IDEX_PERF_CNT_EN defined: adds output bubble_cnt[31:0], zeroed on rst. It increments by 1 on each edge where a bubble is loaded due to flush or load_use_hazard, and not on stall. It wraps from 0xFFFFFFFF to 0.
- Undefined: port absent, no counter logic.

Test Plan:
- rst=1 for 2 cycles with id inputs nonzero → ex_valid=0, all control 0, alu_ctrl=0, alu_A=alu_B=0.
- Load rs=3 (data 5), rt=4 (data 7), ctrl=4'd2, no forwarding → next cycle alu_A=5, alu_B=7, alu_ctrl=2, ex_valid=1.
- Registered rs=3 with mem_rd=3 (mem_alu_res=0x10) and wb_rd=3 (wb_data=0x20), both writing → alu_A=0x10. Same with rs=0 → stored value, no forwarding.
- EX holds lw to r8; ID reads rs=8 with in_valid=1 → load_use_hazard=1, next cycle ex_valid=0, ex_reg_write=0. Instruction reloads the following cycle with alu_A=wb/mem forwarded value.
- stall=1 for 3 cycles while wb writes r4=0x55 in cycle 1 only, registered rt=4 → alu_B=0x55 in cycles 2 and 3; flush=1 together with stall=1 → bubble loaded.
- With IDEX_PERF_CNT_EN: 2 flushes + 1 load-use + 4 stall cycles → bubble_cnt=3.
